// File: rtl/julia_pkg.sv
// Shared constants and types for the Julia renderer pixel write path.
// Frame geometry, pixel bus widths, write request bundle, drain FSM states.
package julia_pkg;
   localparam int FRAME_W      = 640;
   localparam int FRAME_H      = 480;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int PIX_ADDR_W   = 32;
   localparam int PIX_DATA_W   = 32;

   typedef struct packed {
      logic [PIX_ADDR_W-1:0] addr;
      logic [PIX_DATA_W-1:0] data;
   } wr_req_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DRAINED
   } fifo_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO of write requests.
// Power-of-two depth, so the pointers wrap for free.
module sync_fifo
   import julia_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  wr_req_t       wr_req,
   input  logic          rd_en,
   output wr_req_t       rd_req,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   wr_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign do_wr  = wr_en && !full;
   assign do_rd  = rd_en && !empty;
   assign rd_req = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_wr && !do_rd) begin
            count <= count + 1'b1;
         end else if (do_rd && !do_wr) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_wr_fifo.sv
// Pixel write buffer between julia_wrapper and the SDRAM Avalon master.
// Adds drain handshake and per-frame pixel counting on top of sync_fifo.
module pixel_wr_fifo
   import julia_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = julia_pkg::PIX_ADDR_W,
   parameter int DATA_W       = julia_pkg::PIX_DATA_W,
   parameter int FRAME_PIXELS = julia_pkg::FRAME_PIXELS,
   parameter int CNT_W        = 19,
   localparam int FW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_wen,
   output logic              in_wait,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_write,
   input  logic              m_waitrequest,
   input  logic              drain_req,
   output logic              drained,
   input  logic              frame_clear,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pixel_count,
   output logic [FW-1:0]     fill_level
);

   fifo_state_t state;
   wr_req_t     wr_req;
   wr_req_t     head;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   assign in_wait = full || (state != RUN);
   assign push    = in_wen && !in_wait;
   assign m_write = !empty;
   assign pop     = m_write && !m_waitrequest;

   assign wr_req.addr = PIX_ADDR_W'(in_addr);
   assign wr_req.data = PIX_DATA_W'(in_data);

   // Masked when empty so stale storage never shows on the bus.
   assign m_address   = empty ? '0 : ADDR_W'(head.addr);
   assign m_writedata = empty ? '0 : DATA_W'(head.data);

   sync_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (push),
      .wr_req(wr_req),
      .rd_en (pop),
      .rd_req(head),
      .count (fill_level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         drained <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (drain_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!drain_req) begin
                  state <= RUN;
               end else if (empty) begin
                  state   <= DRAINED;
                  drained <= 1'b1;
               end
            end
            DRAINED: begin
               if (!drain_req) begin
                  state   <= RUN;
                  drained <= 1'b0;
               end
            end
            default: begin
               state   <= RUN;
               drained <= 1'b0;
            end
         endcase
      end
   end

   // Set on the frame's last pop beats a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         if (pop && (pixel_count == CNT_W'(FRAME_PIXELS - 1))) begin
            pixel_count <= '0;
            frame_done  <= 1'b1;
         end else begin
            if (pop) begin
               pixel_count <= pixel_count + 1'b1;
            end
            if (frame_clear) begin
               frame_done <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_wr_fifo.sv
// Directed bench for pixel_wr_fifo with a small frame size.
// Expected values are hand-derived per cycle.
module tb_pixel_wr_fifo;

   logic        clk;
   logic        rst;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic        in_wen;
   logic        in_wait;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic        m_write;
   logic        m_waitrequest;
   logic        drain_req;
   logic        drained;
   logic        frame_clear;
   logic        frame_done;
   logic [18:0] pixel_count;
   logic [4:0]  fill_level;

   int n_chk;
   int n_fail;

   pixel_wr_fifo #(
      .DEPTH       (16),
      .ADDR_W      (32),
      .DATA_W      (32),
      .FRAME_PIXELS(8),
      .CNT_W       (19)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .in_wen       (in_wen),
      .in_wait      (in_wait),
      .m_address    (m_address),
      .m_writedata  (m_writedata),
      .m_write      (m_write),
      .m_waitrequest(m_waitrequest),
      .drain_req    (drain_req),
      .drained      (drained),
      .frame_clear  (frame_clear),
      .frame_done   (frame_done),
      .pixel_count  (pixel_count),
      .fill_level   (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_addr       = '0;
      in_data       = '0;
      in_wen        = 1'b0;
      m_waitrequest = 1'b0;
      drain_req     = 1'b0;
      frame_clear   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      m_waitrequest = 1'b1;
      for (int i = 0; i < n; i++) begin
         in_wen  = 1'b1;
         in_addr = base + i;
         in_data = 32'hA000_0000 + base + i;
         step();
      end
      in_wen = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      idle_inputs();
      rst = 1'b1;
      #1;
      check("rst_m_write", m_write, 0);
      check("rst_in_wait", in_wait, 0);
      check("rst_m_address", m_address, 0);
      check("rst_m_writedata", m_writedata, 0);
      check("rst_drained", drained, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_pixel_count", pixel_count, 0);
      check("rst_fill", fill_level, 0);
      step();
      step();
      rst = 1'b0;

      // single write
      in_wen  = 1'b1;
      in_addr = 32'h100;
      in_data = 32'h00FF00FF;
      step();
      in_wen = 1'b0;
      check("t1_m_write", m_write, 1);
      check("t1_addr", m_address, 32'h100);
      check("t1_data", m_writedata, 32'h00FF00FF);
      check("t1_fill1", fill_level, 1);
      step();
      check("t1_m_write_off", m_write, 0);
      check("t1_pixel_count", pixel_count, 1);
      check("t1_fill0", fill_level, 0);

      // fill to full
      do_reset();
      push_n(15, 0);
      check("t2_fill15", fill_level, 15);
      check("t2_wait_at15", in_wait, 0);
      push_n(1, 15);
      check("t2_fill16", fill_level, 16);
      check("t2_wait_full", in_wait, 1);
      in_wen  = 1'b1;
      in_addr = 32'd16;
      in_data = 32'hDEAD_BEEF;
      step();
      step();
      check("t2_hold_fill", fill_level, 16);
      check("t2_hold_wait", in_wait, 1);
      check("t2_hold_head", m_address, 0);
      in_wen        = 1'b0;
      m_waitrequest = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_addr%0d", i), m_address, i);
         check($sformatf("t2_data%0d", i), m_writedata, 32'hA000_0000 + i);
         step();
         if (i == 0) begin
            check("t2_fill_after_pop", fill_level, 15);
            check("t2_wait_released", in_wait, 0);
         end
      end
      check("t2_empty", m_write, 0);
      check("t2_count", pixel_count, 0);
      check("t2_done", frame_done, 1);

      // stall hold
      do_reset();
      push_n(4, 32'h200);
      begin
         int idx;
         idx = 0;
         for (int c = 0; c < 20; c++) begin
            if (idx < 4) begin
               m_waitrequest = (c % 2 == 0);
               check($sformatf("t3_wr_c%0d", c), m_write, 1);
               check($sformatf("t3_addr_c%0d", c), m_address, 32'h200 + idx);
               check($sformatf("t3_data_c%0d", c), m_writedata,
                     32'hA000_0200 + idx);
               step();
               if (c % 2 != 0) idx++;
            end
         end
         check("t3_popped", idx, 4);
      end
      m_waitrequest = 1'b0;
      check("t3_empty", m_write, 0);
      check("t3_count", pixel_count, 4);

      // frame wrap
      do_reset();
      push_n(9, 32'h400);
      m_waitrequest = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         frame_clear = (k == 8);
         step();
         check($sformatf("t4_count_%0d", k), pixel_count, k % 8);
         check($sformatf("t4_done_%0d", k), frame_done, (k >= 8));
      end
      frame_clear = 1'b1;
      step();
      frame_clear = 1'b0;
      check("t4_cleared", frame_done, 0);
      check("t4_count_hold", pixel_count, 1);

      // drain handshake
      do_reset();
      push_n(5, 32'h300);
      drain_req = 1'b1;
      step();
      check("t5_wait_drain", in_wait, 1);
      check("t5_not_drained", drained, 0);
      in_wen        = 1'b1;
      in_addr       = 32'h999;
      in_data       = 32'h999;
      m_waitrequest = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t5_addr%0d", i), m_address, 32'h300 + i);
         step();
      end
      check("t5_fill0", fill_level, 0);
      check("t5_drained_early", drained, 0);
      step();
      check("t5_drained", drained, 1);
      check("t5_no_push", fill_level, 0);
      check("t5_m_write", m_write, 0);
      check("t5_count", pixel_count, 5);
      in_wen    = 1'b0;
      drain_req = 1'b0;
      step();
      check("t5_undrained", drained, 0);
      check("t5_wait_off", in_wait, 0);

      // async reset mid-burst
      do_reset();
      push_n(12, 32'h500);
      m_waitrequest = 1'b0;
      step();
      step();
      m_waitrequest = 1'b1;
      check("t6_buffered", fill_level, 10);
      check("t6_count_pre", pixel_count, 2);
      #2;
      rst = 1'b1;
      #1;
      check("t6_m_write", m_write, 0);
      check("t6_fill", fill_level, 0);
      check("t6_count", pixel_count, 0);
      check("t6_done", frame_done, 0);
      check("t6_addr", m_address, 0);
      step();
      rst           = 1'b0;
      m_waitrequest = 1'b0;
      step();
      check("t6_no_writes", m_write, 0);
      check("t6_count_post", pixel_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_wr_fifo.md
Name: pixel_wr_fifo

Overview:
- Buffers the pixel write stream from the julia_wrapper memory-controller output (wr_addr/wr_data/wr_enable) and drains it to the SDRAM Avalon-MM write master port.
- Absorbs SDRAM stalls so that the 16 Julia workers keep computing.
- Counts drained pixels per frame and raises a sticky frame_done flag.
- Provides a drain handshake so that software can quiesce the path before changing c (a/b) or restarting.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 32, write address width
DATA_W, 32, write data (colour) width
FRAME_PIXELS, 307200, pixels per frame (640x480); sets when frame_done fires
CNT_W, 19, pixel counter width; must satisfy 2^CNT_W >= FRAME_PIXELS

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_addr  in  ADDR_W  write address from julia_wrapper wr_addr
in_data  in  DATA_W  write data from julia_wrapper wr_data
in_wen  in  1  write request from julia_wrapper wr_enable
in_wait  out  1  back-pressure to julia_wrapper wait_request
m_address  out  ADDR_W  Avalon master address
m_writedata  out  DATA_W  Avalon master write data
m_write  out  1  Avalon master write strobe
m_waitrequest  in  1  Avalon slave stall
drain_req  in  1  level; stop accepting new writes and empty the FIFO
drained  out  1  FIFO empty and intake blocked while drain_req=1
frame_clear  in  1  one-cycle pulse; clears frame_done
frame_done  out  1  sticky; the last pixel of a frame has been written
pixel_count  out  CNT_W  pixels drained in the current frame
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - All outputs 0: in_wait, m_write, m_address, m_writedata, drained, frame_done, pixel_count, fill_level.
  - FSM goes to RUN.
  - Pointers are cleared.
- Reset mid-operation discards all buffered entries without issuing writes.

Push:
- A push occurs when in_wen=1 and in_wait=0 in the same cycle.
- in_wait = (fill_level==DEPTH) || (state!=RUN).
- in_wait is derived only from registered state; there is no combinational path from m_waitrequest or in_wen.
- Full and pop in the same cycle: no push (in_wait is already 1). The slot frees on the next cycle.

Pop (show-ahead):
- m_write = (fill_level!=0).
- m_address and m_writedata are driven from the head entry.
- Pop when m_write=1 and m_waitrequest=0.
- Outputs stay stable while m_waitrequest=1 (Avalon hold rule).
- Latency: a push into an empty FIFO produces m_write=1 on the next cycle.
- Empty and push in the same cycle: no pop, and fill_level becomes 1.
- Simultaneous push and pop when not full: fill_level unchanged.
- Pointers wrap modulo DEPTH.

Pixel counter:
- Increments on each pop.
- On the pop where pixel_count==FRAME_PIXELS-1, pixel_count wraps to 0 and frame_done is set.
- frame_done stays set until frame_clear. If set and clear occur in the same cycle, set wins.

FSM:
- RUN: accept pushes. If drain_req=1, go to DRAIN (in_wait=1 from the next cycle).
- DRAIN: no pushes; continue popping.
  - If fill_level==0 (including on entry), go to DRAINED.
  - If drain_req=0, go back to RUN.
- DRAINED: drained=1. Stay while drain_req=1. If drain_req=0, go to RUN with drained=0 in the same transition cycle.
- drained is registered; it is 1 only in DRAINED.

Decomposition:
- Package julia_pkg holds:
  - FRAME_W=640, FRAME_H=480, FRAME_PIXELS
  - PIX_ADDR_W=32, PIX_DATA_W=32
  - typedef wr_req_t, a packed struct {addr, data}
  - enum fifo_state_t {RUN, DRAIN, DRAINED}
- One sub-module, sync_fifo: parameterised storage of wr_req_t with read/write pointers, count, full and empty. It is reusable elsewhere.
- pixel_wr_fifo contains the FSM, the handshake glue, and the pixel/frame counters.

Test Plan:
- Reset and single write: deassert rst, pulse in_wen with addr=0x100, data=0x00FF00FF; m_waitrequest=0. Required: m_write=1 on the next cycle with the same values for exactly 1 cycle, pixel_count=1, fill_level returns to 0.
- Fill to full: hold m_waitrequest=1 and push 16 entries (addr=0..15). Required:
  - in_wait=1 once fill_level=16, and the 17th request is held with no push.
  - Release m_waitrequest: writes drain in order 0..15, and in_wait=0 the cycle after the first pop.
- Stall hold: during a drain, toggle m_waitrequest 1/0 on alternate cycles. Required: m_address/m_writedata unchanged during stalls, each entry is written exactly once, no loss or duplication.
- Frame wrap: set FRAME_PIXELS=8 and drain 9 pixels. Required:
  - frame_done rises on the 8th pop and pixel_count goes to 0 then 1.
  - frame_clear in the same cycle as the set leaves frame_done=1; a later frame_clear gives 0.
- Drain handshake: load 5 entries, assert drain_req. Required: in_wait=1 from the next cycle, 5 writes issued, then drained=1. Deassert drain_req: drained=0 and in_wait=0.
- Async reset: assert rst mid-burst with 10 entries buffered. Required: m_write=0 immediately (no clock edge), fill_level=0, pixel_count=0, frame_done=0.
